c17_bist_ctrl: RTL and testbench
================================

// Module: c17_bist_ctrl
// PURPOSE
//   Built-in self-test wrapper stage around the c17 combinational core.
//   Sits directly upstream and downstream of c17: an LFSR pattern generator drives N1,N2,N3,N6,N7.
//   A MISR compacts N22/N23 into a signature that is compared against a golden value.
//   A 3-state FSM sequences one test run per start pulse and reports done/pass.
// PARAMETERS
//   NUM_PATTERNS  31        patterns applied per run, 1..31 (31 = full LFSR period)
//   SEED          5'h01     LFSR load value at start; must be nonzero
//   SIG_W         16        MISR width, >= 2
//   MISR_POLY     16'h1021  MISR Galois feedback mask (x^16+x^12+x^5+1)
//   GOLDEN_SIG    16'h0000  expected final signature; set by the integrator from the golden model
// PORTS
//   clk      in   1      single clock, rising edge
//   rst_n    in   1      synchronous active-low reset
//   start    in   1      one-cycle run request; honoured only in IDLE or DONE
//   N1       out  1      pattern bit 4 to c17
//   N2       out  1      pattern bit 3 to c17
//   N3       out  1      pattern bit 2 to c17
//   N6       out  1      pattern bit 1 to c17
//   N7       out  1      pattern bit 0 to c17
//   N22      in   1      c17 response, folded into MISR bit 1
//   N23      in   1      c17 response, folded into MISR bit 0
//   busy     out  1      high in RUN
//   done     out  1      high in DONE; held until the next start or reset
//   pass     out  1      valid while done: signature == GOLDEN_SIG
//   sig      out  SIG_W  current MISR contents
// BEHAVIOUR
//   Reset (rst_n=0 at an edge) sets:
//     state=IDLE, lfsr=0, misr=0, count=0
//     N*=0, busy=0, done=0, pass=0
//   Reset mid-RUN aborts the run with no residual state.
//   LFSR (5b Fibonacci, x^5+x^3+1, period 31):
//     lfsr_nxt = {lfsr[3:0], lfsr[4]^lfsr[2]}
//     {N1,N2,N3,N6,N7} = lfsr, driven straight from flops
//   MISR:
//     misr_nxt = {misr[SIG_W-2:0],1'b0} ^ (misr[SIG_W-1] ? MISR_POLY : 0) ^ {{SIG_W-2{1'b0}}, N22, N23}
//   FSM:
//     IDLE: start -> RUN; load lfsr=SEED, misr=0, count=0.
//     RUN:
//       - Each edge: misr<=misr_nxt (captures the response to the pattern present this cycle), lfsr<=lfsr_nxt, count<=count+1.
//       - When count==NUM_PATTERNS-1, that edge also moves to DONE.
//       - The lfsr step on this final edge is harmless.
//       - start is ignored in RUN.
//     DONE: misr frozen; pass registered on DONE entry from misr_nxt==GOLDEN_SIG; start -> RUN with the same reload as IDLE.
//   Latency and timing:
//     - start-to-done = NUM_PATTERNS+1 cycles.
//     - Exactly NUM_PATTERNS responses are absorbed, none twice.
//   Other rules:
//     - count is 5 bits; it never wraps inside a run.
//     - start together with rst_n=0: reset wins.
// STRUCTURE
//   Package c17_bist_pkg:
//     - state enum {IDLE, RUN, DONE}
//     - LFSR width and tap constants
//     - default MISR_POLY and SIG_W
//   Sub-module bist_misr (SIG_W, MISR_POLY): inputs clr, en, din[1:0]; output sig.
//   LFSR, counter and FSM stay in c17_bist_ctrl.
// TESTING (bench instantiates c17 between the N* ports; golden model computes expected sig)
//   1. Reset, then start. Required:
//      - N{1,2,3,6,7} sequence 00001,00010,00100,01001,10010,00101.
//      - First pattern 00001 gives N22=0, N23=1.
//      - busy high for exactly 31 cycles.
//   2. Full run with GOLDEN_SIG = model signature. Required:
//      - done on cycle 32 after start.
//      - pass=1, sig equals model.
//   3. Same run with one c17 output stuck-at-0 (N23 forced 0). Required:
//      - sig differs from the golden value, pass=0.
//      - done still rises on cycle 32.
//   4. Pulse start at cycle 10 of RUN. Required:
//      - Ignored; done timing and sig unchanged.
//      - A start while in DONE restarts the run and reproduces an identical sig.
//   5. Drop rst_n at cycle 15 of RUN for one edge. Required:
//      - Next cycle all outputs are 0, state is IDLE.
//      - A following start yields the full golden signature.
//   6. NUM_PATTERNS=1. Required:
//      - done 2 cycles after start.
//      - sig = misr_nxt of response 01 from 0, i.e. 16'h0001.

Source files
------------

// File: rtl/c17_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c17_bist_pkg
//  Description : Shared types and constants for the c17 BIST wrapper:
//                FSM state encoding, LFSR geometry and taps, MISR defaults,
//                and the LFSR step function.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package c17_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 5-bit Fibonacci LFSR, x^5 + x^3 + 1, maximal period 31
    localparam int c_lfsr_w     = 5;
    localparam int c_lfsr_tap_a = 4;
    localparam int c_lfsr_tap_b = 2;

    // Pattern counter width; covers NUM_PATTERNS up to 31 without wrapping
    localparam int c_cnt_w = 5;

    // MISR defaults (x^16 + x^12 + x^5 + 1)
    localparam int          c_def_sig_w     = 16;
    localparam logic [15:0] c_def_misr_poly = 16'h1021;

    function automatic logic [c_lfsr_w-1:0] lfsr_step(input logic [c_lfsr_w-1:0] s);
        return {s[c_lfsr_w-2:0], s[c_lfsr_tap_a] ^ s[c_lfsr_tap_b]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/c17_bist_ctrl_misr.sv
`default_nettype none
// ============================================================================
//  Module      : bist_misr
//  Description : Galois-style multiple-input signature register that folds a
//                2-bit response into its low bits each enabled cycle.
//  Ports       : clk     - clock, rising edge
//                rst_n   - synchronous active-low reset (clears signature)
//                clr     - synchronous clear, takes priority over en
//                en      - absorb din this cycle
//                din     - response bits {N22, N23}
//                sig     - current signature
//                sig_nxt - signature that would be loaded on an enabled edge
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_misr
    import c17_bist_pkg::*;
#(
    parameter int               SIG_W     = c_def_sig_w,
    parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(c_def_misr_poly)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       din,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_nxt
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_nxt;

    always_comb begin
        w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0}
                  ^ (r_sig[SIG_W-1] ? MISR_POLY : '0)
                  ^ {{(SIG_W-2){1'b0}}, din};
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_sig <= '0;
        end else if (en) begin
            r_sig <= w_sig_nxt;
        end
    end

    assign sig     = r_sig;
    assign sig_nxt = w_sig_nxt;

endmodule
`default_nettype wire

// File: rtl/c17_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : c17_bist_ctrl
//  Description : BIST wrapper for the c17 core. An LFSR drives the five c17
//                inputs, a MISR compacts the two responses, and a 3-state FSM
//                runs NUM_PATTERNS patterns per start pulse, then reports
//                done and pass (signature == GOLDEN_SIG).
//  Ports       : clk, rst_n (sync, active low), start
//                N1,N2,N3,N6,N7 - pattern bits 4..0 to c17
//                N22,N23        - c17 responses
//                busy, done, pass, sig[SIG_W-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int                  NUM_PATTERNS = 31,
    parameter logic [c_lfsr_w-1:0] SEED         = 5'h01,
    parameter int                  SIG_W        = c_def_sig_w,
    parameter logic [SIG_W-1:0]    MISR_POLY    = SIG_W'(c_def_misr_poly),
    parameter logic [SIG_W-1:0]    GOLDEN_SIG   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             N1,
    output logic             N2,
    output logic             N3,
    output logic             N6,
    output logic             N7,
    input  logic             N22,
    input  logic             N23,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig
);

    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NUM_PATTERNS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_lfsr_w-1:0]  r_lfsr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_pass;
    logic                 w_load;
    logic                 w_last;
    logic                 w_misr_en;
    logic [SIG_W-1:0]     w_sig_nxt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        w_misr_en   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                w_misr_en = 1'b1;
                if (r_count == c_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pattern generator, pattern counter and pass flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr  <= '0;
            r_count <= '0;
            r_pass  <= 1'b0;
        end else if (w_load) begin
            r_lfsr  <= SEED;
            r_count <= '0;
            r_pass  <= 1'b0;
        end else if (r_state == ST_RUN) begin
            // The step taken on the final edge is never absorbed: the MISR
            // freezes in DONE and the next start reloads SEED.
            r_lfsr  <= lfsr_step(r_lfsr);
            r_count <= r_count + 1'b1;
            if (w_last) begin
                // Compare the signature being loaded on this same edge so
                // that pass is valid in the first DONE cycle.
                r_pass <= (w_sig_nxt == GOLDEN_SIG);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response compactor
    // ------------------------------------------------------------------
    bist_misr #(
        .SIG_W     (SIG_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_load),
        .en      (w_misr_en),
        .din     ({N22, N23}),
        .sig     (sig),
        .sig_nxt (w_sig_nxt)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign {N1, N2, N3, N6, N7} = r_lfsr;
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign pass = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_c17_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c17_bist_ctrl
//  Description : Self-checking bench for c17_bist_ctrl. A behavioural c17
//                closes the loop between pattern outputs and response inputs;
//                a reference model supplies the golden signature, and a
//                scoreboard queue holds expected run results until done.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_c17_bist_ctrl;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          edges;
    } exp_t;

    // c17 netlist: six 2-input NANDs, returns {N22, N23}
    function automatic logic [1:0] c17f(input logic [4:0] p);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
        {n1, n2, n3, n6, n7} = p;
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

    function automatic logic [15:0] model_sig(input int n, input logic stuck23);
        logic [4:0]  l;
        logic [15:0] m;
        logic [1:0]  r;
        l = 5'h01;
        m = 16'h0000;
        for (int i = 0; i < n; i++) begin
            r = c17f(l);
            if (stuck23) r[0] = 1'b0;
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {14'b0, r};
            l = {l[3:0], l[4] ^ l[2]};
        end
        return m;
    endfunction

    localparam logic [15:0] c_gold = model_sig(31, 1'b0);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start1;
    logic        fault;

    logic        N1, N2, N3, N6, N7;
    logic [1:0]  resp;
    logic        N22, N23;
    logic        busy, done, pass;
    logic [15:0] sig;

    logic        p1_1, p2_1, p3_1, p6_1, p7_1;
    logic [1:0]  resp1;
    logic        busy1, done1, pass1;
    logic [15:0] sig1;

    int          n_checks = 0;
    int          n_fail   = 0;

    exp_t        sb_q[$];
    logic [4:0]  pat_q[$];

    always #5 clk = ~clk;

    assign resp  = c17f({N1, N2, N3, N6, N7});
    assign N22   = resp[1];
    assign N23   = fault ? 1'b0 : resp[0];
    assign resp1 = c17f({p1_1, p2_1, p3_1, p6_1, p7_1});

    c17_bist_ctrl #(
        .NUM_PATTERNS (31),
        .SEED         (5'h01),
        .SIG_W        (16),
        .MISR_POLY    (16'h1021),
        .GOLDEN_SIG   (c_gold)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .N1    (N1),
        .N2    (N2),
        .N3    (N3),
        .N6    (N6),
        .N7    (N7),
        .N22   (N22),
        .N23   (N23),
        .busy  (busy),
        .done  (done),
        .pass  (pass),
        .sig   (sig)
    );

    c17_bist_ctrl #(
        .NUM_PATTERNS (1),
        .SEED         (5'h01),
        .SIG_W        (16),
        .MISR_POLY    (16'h1021),
        .GOLDEN_SIG   (16'h0000)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .N1    (p1_1),
        .N2    (p2_1),
        .N3    (p3_1),
        .N6    (p6_1),
        .N7    (p7_1),
        .N22   (resp1[1]),
        .N23   (resp1[0]),
        .busy  (busy1),
        .done  (done1),
        .pass  (pass1),
        .sig   (sig1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full run on dut: push expectations, pulse start, follow the run
    // until done (bounded), then pop and compare.
    task automatic run(input logic stuck, input int inj_start, input logic check_pats);
        exp_t       e;
        logic [4:0] p;
        int         edges;
        int         busy_cnt;
        e.sig   = model_sig(31, stuck);
        e.pass  = (e.sig == c_gold);
        e.edges = 32;
        sb_q.push_back(e);
        if (check_pats) begin
            pat_q.push_back(5'b00001);
            pat_q.push_back(5'b00010);
            pat_q.push_back(5'b00100);
            pat_q.push_back(5'b01001);
            pat_q.push_back(5'b10010);
            pat_q.push_back(5'b00101);
        end
        fault = stuck;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        edges    = 1;
        busy_cnt = 0;
        while (!done && edges < 200) begin
            if (check_pats && edges == 1) begin
                check("first_resp", {30'b0, N22, N23}, 32'b01);
            end
            if (pat_q.size() > 0) begin
                p = pat_q.pop_front();
                check("pattern", {27'b0, N1, N2, N3, N6, N7}, {27'b0, p});
            end
            if (busy) busy_cnt++;
            start = (edges == inj_start);
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check("done_latency", edges, e.edges);
        check("busy_cycles", busy_cnt, 31);
        check("sig", {16'b0, sig}, {16'b0, e.sig});
        check("pass", {31'b0, pass}, {31'b0, e.pass});
        if (stuck) begin
            check("sig_differs", {31'b0, (sig != c_gold)}, 32'd1);
        end
        repeat (3) @(negedge clk);
        check("done_held", {31'b0, done}, 32'd1);
        check("sig_frozen", {16'b0, sig}, {16'b0, e.sig});
        fault = 1'b0;
    endtask

    initial begin
        int edges;
        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        fault  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_pattern", {27'b0, N1, N2, N3, N6, N7}, 32'd0);
        check("rst_flags", {29'b0, busy, done, pass}, 32'd0);
        check("rst_sig", {16'b0, sig}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pattern sequence, busy width, golden pass
        run(1'b0, -1, 1'b1);
        // Stuck-at-0 on N23, started from DONE
        run(1'b1, -1, 1'b0);
        // Start mid-run ignored; restart from DONE reproduces signature
        run(1'b0, 10, 1'b0);
        run(1'b0, -1, 1'b0);

        // Reset at cycle 15 of a run
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        edges = 1;
        while (edges < 15) begin
            @(negedge clk);
            edges++;
        end
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        check("abort_pattern", {27'b0, N1, N2, N3, N6, N7}, 32'd0);
        check("abort_flags", {29'b0, busy, done, pass}, 32'd0);
        check("abort_sig", {16'b0, sig}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {30'b0, busy, done}, 32'd0);
        run(1'b0, -1, 1'b0);

        // start together with reset: reset wins
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        check("rst_beats_start", {30'b0, busy, done}, 32'd0);
        @(negedge clk);
        check("rst_beats_start_idle", {30'b0, busy, done}, 32'd0);

        // NUM_PATTERNS = 1 instance
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        edges = 1;
        while (!done1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("np1_latency", edges, 32'd2);
        check("np1_sig", {16'b0, sig1}, 32'h0001);
        check("np1_pass", {31'b0, pass1}, 32'd0);
        check("np1_busy", {31'b0, busy1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
